lfsr_keystream_xor: RTL and testbench

Downstream consumer of the 26-bit free-running LFSR. It seeds the LFSR through the LFSR's load/din inputs and discards a warm-up period. It then packs the LFSR output bit into DATA_W-bit key words, buffers them in a small FIFO, and XORs them onto a valid/ready data stream. It sits between the LFSR and the byte-stream cipher datapath.

---
 rtl/lfsr_keystream_xor_if.sv | 12 +
 rtl/lfsr_keystream_xor.sv | 140 ++++++++++++++
 tb/tb_lfsr_keystream_xor.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_keystream_xor_if.sv
// Valid/ready word stream carrying plaintext into, and ciphertext out of, lfsr_keystream_xor.
// The master drives data/valid; the slave drives ready.
interface lfsr_keystream_xor_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lfsr_keystream_xor.sv
// Seeds an external 26-bit LFSR, skips a warm-up, packs its output bit into key words and XORs
// them onto a valid/ready stream. Defining LFSR_KSX_WORD_CNT_EN adds the word_cnt output port.
module lfsr_keystream_xor #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int WARMUP     = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [25:0]         seed,
   output logic                lfsr_load,
   output logic [1:26]         lfsr_din,
   input  logic [1:26]         lfsr_q,
   lfsr_keystream_xor_if.slave  s,
   lfsr_keystream_xor_if.master m,
   output logic                running,
   output logic                overflow
`ifdef LFSR_KSX_WORD_CNT_EN
   ,
   output logic [15:0]         word_cnt
`endif
);
   localparam int WARM_CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [WARM_CW-1:0] WARM_LAST = (WARMUP > 0) ? WARM_CW'(WARMUP - 1) : '0;
   localparam int BIT_CW = $clog2(DATA_W);
   localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

   state_t              state;
   logic [WARM_CW-1:0]  warm_cnt;
   logic [DATA_W-2:0]   col_q;
   logic [BIT_CW-1:0]   bit_cnt;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [DATA_W-1:0]   key_word;
   logic [DATA_W-1:0]   head;
   logic                fifo_empty;
   logic                fifo_full;
   logic                word_done;
   logic                pop;
   logic                push;
   logic                unused_lfsr_bits;

   // Only the tail bit of the LFSR is keystream; the rest of the state is deliberately ignored.
   assign unused_lfsr_bits = ^lfsr_q[1:25];

   // The collector holds the previous DATA_W-1 samples, oldest at bit 0, so the completed word
   // puts the first sampled bit in the LSB.
   assign key_word   = {lfsr_q[26], col_q};
   assign head       = fifo_mem[rd_ptr[AW-1:0]];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign word_done  = running && (bit_cnt == BIT_LAST);
   assign s.ready    = running && !fifo_empty && (!m.valid || m.ready);
   assign pop        = s.valid && s.ready;
   assign push       = word_done && (!fifo_full || pop);

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         warm_cnt  <= '0;
         lfsr_load <= 1'b0;
         lfsr_din  <= '0;
         running   <= 1'b0;
      end else if (start) begin
         state     <= LOAD;
         warm_cnt  <= '0;
         lfsr_load <= 1'b1;
         lfsr_din  <= (seed == 26'd0) ? 26'd1 : seed;
         running   <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               lfsr_load <= 1'b0;
               warm_cnt  <= '0;
               if (WARMUP == 0) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else begin
                  state <= WARM;
               end
            end
            WARM: begin
               if (warm_cnt == WARM_LAST) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         col_q    <= '0;
         bit_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         m.valid  <= 1'b0;
         m.data   <= '0;
      end else begin
         if (running) begin
            col_q   <= key_word[DATA_W-1:1];
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         // The LFSR cannot stall, so a completed word with nowhere to go is lost.
         if (word_done && !push) overflow <= 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            m.valid <= 1'b1;
            m.data  <= s.data ^ head;
         end else if (m.ready) begin
            m.valid <= 1'b0;
         end
      end
   end

   // NOTE: the key storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= key_word;
   end

`ifdef LFSR_KSX_WORD_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || start) word_cnt <= '0;
      else if (m.valid && m.ready) word_cnt <= word_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_lfsr_keystream_xor.sv
// Bench for lfsr_keystream_xor: stub LFSR bit source, scoreboard of key words and XOR results,
// plus WARMUP=3 and WARMUP=0 instances for warm-up timing.
module tb_lfsr_keystream_xor;
   localparam int W         = 8;
   localparam int DEPTH     = 4;
   localparam int WARM_MAIN = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [25:0] seed = '0;
   logic [1:26] lfsr_q = '0;

   logic        load_m, load_3, load_0;
   logic [1:26] din_m, din_3, din_0;
   logic        run_m, run_3, run_0;
   logic        ovf_m, ovf_3, ovf_0;
`ifdef LFSR_KSX_WORD_CNT_EN
   logic [15:0] wc_m, wc_3, wc_0;
`endif

   lfsr_keystream_xor_if #(.DATA_W(W)) s_m(), m_m(), s_3(), m_3(), s_0(), m_0();

   lfsr_keystream_xor #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .WARMUP(WARM_MAIN)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
      .lfsr_load(load_m), .lfsr_din(din_m), .lfsr_q(lfsr_q),
      .s(s_m), .m(m_m), .running(run_m), .overflow(ovf_m)
`ifdef LFSR_KSX_WORD_CNT_EN
      , .word_cnt(wc_m)
`endif
   );

   lfsr_keystream_xor #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .WARMUP(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
      .lfsr_load(load_3), .lfsr_din(din_3), .lfsr_q(lfsr_q),
      .s(s_3), .m(m_3), .running(run_3), .overflow(ovf_3)
`ifdef LFSR_KSX_WORD_CNT_EN
      , .word_cnt(wc_3)
`endif
   );

   lfsr_keystream_xor #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .WARMUP(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
      .lfsr_load(load_0), .lfsr_din(din_0), .lfsr_q(lfsr_q),
      .s(s_0), .m(m_0), .running(run_0), .overflow(ovf_0)
`ifdef LFSR_KSX_WORD_CNT_EN
      , .word_cnt(wc_0)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard state for u_main
   int unsigned  cyc = 0;
   bit           armed = 1'b0;
   int unsigned  sample_from = 0;
   logic [W-1:0] col = '0;
   int           ncol = 0;
   logic [W-1:0] key_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_word;
   int           keys_made = 0;
   int           xfer_cnt = 0;
   int           out_cnt = 0;
   int           out_since_start = 0;
   bit           model_ovf = 1'b0;
   bit           last_xfer = 1'b0;
   bit           hold_pending = 1'b0;
   logic [W-1:0] held = '0;

   always @(posedge clk) begin
      cyc++;
      last_xfer = 1'b0;
      if (!rst_n || start) begin
         key_q.delete();
         exp_q.delete();
         ncol            = 0;
         model_ovf       = 1'b0;
         hold_pending    = 1'b0;
         out_since_start = 0;
         armed           = rst_n;
         sample_from     = cyc + WARM_MAIN + 2;
      end else begin
         if (hold_pending && m_m.valid) check("m_data_hold", m_m.data, held);
         if (m_m.valid && m_m.ready) begin
            check("exp_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               exp_word = exp_q.pop_front();
               check("m_data", m_m.data, exp_word);
            end
            out_cnt++;
            out_since_start++;
         end
         if (s_m.valid && s_m.ready) begin
            xfer_cnt++;
            last_xfer = 1'b1;
            check("key_avail", key_q.size() > 0, 1'b1);
            if (key_q.size() > 0) exp_q.push_back(s_m.data ^ key_q.pop_front());
         end
         hold_pending = m_m.valid && !m_m.ready;
         held         = m_m.data;
         if (armed && cyc >= sample_from) begin
            col = {lfsr_q[26], col[W-1:1]};
            ncol++;
            if (ncol == W) begin
               ncol = 0;
               keys_made++;
               if (key_q.size() < DEPTH) key_q.push_back(col);
               else model_ovf = 1'b1;
            end
         end
      end
   end

   // Stub LFSR: 0 = random bits, 1 = 1,0,1,0... with a 1 in cycle alt_base, 2 = bit_const
   int          bit_mode = 0;
   int unsigned alt_base = 0;
   logic        bit_const = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      lfsr_q[1:25] = 25'($urandom);
      case (bit_mode)
         1:       lfsr_q[26] = ((cyc - alt_base) % 2 == 0);
         2:       lfsr_q[26] = bit_const;
         default: lfsr_q[26] = 1'($urandom);
      endcase
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_load"},     load_m,    1'b0);
      check({pfx, "_din"},      din_m,     26'd0);
      check({pfx, "_s_ready"},  s_m.ready, 1'b0);
      check({pfx, "_m_valid"},  m_m.valid, 1'b0);
      check({pfx, "_m_data"},   m_m.data,  8'h00);
      check({pfx, "_running"},  run_m,     1'b0);
      check({pfx, "_overflow"}, ovf_m,     1'b0);
   endtask

   int unsigned load_cyc;
   int          x0, k0, o0;
   bit          got;

   initial begin
      s_m.valid = 1'b0; s_m.data = '0; m_m.ready = 1'b0;
      s_3.valid = 1'b1; s_3.data = '0; m_3.ready = 1'b0;
      s_0.valid = 1'b0; s_0.data = '0; m_0.ready = 1'b0;

      // Reset values
      rst_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_s_ready", s_m.ready, 1'b0);

      // Seed 0 becomes 1; WARMUP=0 and WARMUP=3 timing
      seed  = 26'd0;
      start = 1'b1;
      tick();
      start    = 1'b0;
      load_cyc = cyc;
      check("seed0_load", load_m, 1'b1);
      check("seed0_din", din_m, 26'd1);
      check("load_running", run_m, 1'b0);
      bit_mode  = 2;
      bit_const = 1'b1;
      tick();
      check("load_one_cycle", load_m, 1'b0);
      check("din_held", din_m, 26'd1);
      check("w0_running", run_0, 1'b1);
      check("w3_warm1", run_3, 1'b0);
      tick();
      check("w3_warm2", run_3, 1'b0);
      tick();
      check("w3_warm3", run_3, 1'b0);
      bit_const = 1'b0;
      tick();
      check("w3_running", run_3, 1'b1);
      repeat (8) tick();
      bit_mode = 0;
      tick();
      tick();
      check("w3_m_valid", m_3.valid, 1'b1);
      check("w3_key_skips_warm", m_3.data, 8'h00);

      // First key 8'h55 from alternating bits starting in the first RUN cycle
      alt_base = load_cyc + WARM_MAIN + 1;
      while (cyc < alt_base - 1) tick();
      bit_mode  = 1;
      s_m.valid = 1'b1;
      s_m.data  = 8'hFF;
      m_m.ready = 1'b0;
      x0  = xfer_cnt;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (s_m.ready) got = 1'b1;
      end
      check("first_key_seen", got, 1'b1);
      check("first_key_cycle", cyc, alt_base + W);
      bit_mode = 0;
      tick();
      check("xfer_latency", m_m.valid, 1'b1);
      check("xor_first", m_m.data, 8'hAA);

      // Backpressure until the key FIFO overflows
      repeat (58) tick();
      check("bp_one_xfer", xfer_cnt - x0, 1);
      check("bp_m_valid", m_m.valid, 1'b1);
      check("bp_m_data", m_m.data, 8'hAA);
      check("bp_overflow", ovf_m, 1'b1);

      // Restart clears overflow and the pending output
      s_m.valid = 1'b0;
      seed      = 26'h2AAAAAA;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("seed_load", load_m, 1'b1);
      check("seed_din", din_m, 26'h2AAAAAA);
      check("restart_overflow", ovf_m, 1'b0);
      check("restart_m_valid", m_m.valid, 1'b0);
      check("restart_s_ready", s_m.ready, 1'b0);

      // Continuous flow: key-limited throughput against the bit-sequence model
      s_m.valid = 1'b1;
      s_m.data  = 8'($urandom);
      m_m.ready = 1'b1;
      k0 = keys_made;
      o0 = out_cnt;
      for (int i = 0; i < 166; i++) begin
         tick();
         if (last_xfer) s_m.data = 8'($urandom);
      end
      check("tp_keys", (keys_made - k0) >= 12, 1'b1);
      check("tp_rate", ((keys_made - k0) - (out_cnt - o0)) <= 2, 1'b1);
      check("tp_overflow", ovf_m, 1'b0);
`ifdef LFSR_KSX_WORD_CNT_EN
      check("tp_word_cnt", wc_m, 16'(out_since_start));
`endif

      // Buffered keys drain back-to-back
      s_m.valid = 1'b0;
      repeat (24) tick();
      s_m.valid = 1'b1;
      x0 = xfer_cnt;
      for (int i = 0; i < 3; i++) begin
         tick();
         s_m.data = 8'($urandom);
      end
      check("b2b_xfers", xfer_cnt - x0, 3);
      check("b2b_m_valid", m_m.valid, 1'b1);

      // Reset mid-RUN with an output word pending
      m_m.ready = 1'b0;
      tick();
      check("pre_rst_m_valid", m_m.valid, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_outputs("midrst");
`ifdef LFSR_KSX_WORD_CNT_EN
      check("midrst_word_cnt", wc_m, 16'd0);
`endif
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_s_ready", s_m.ready, 1'b0);
      end
      check("post_rst_running", run_m, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
